rv32_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the rv32_cpu decode logic.
- Acts as the Wishbone classic master on the ibus.
- Buffers fetched words in a small prefetch FIFO.
- Presents {pc, insn, fault} to the core over a valid/ready handshake.
- Accepts redirects from branches, jumps and traps, flushing any stale prefetches.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/rv32_fetch_fifo.sv | 62 ++++++
 rtl/rv32_fetch.sv | 150 +++++++++++++++
 tb/tb_rv32_fetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared fetch-stage types and Wishbone constants.
// Imported by rv32_fetch and rv32_fetch_fifo.
package rv32_pkg;

    localparam logic [2:0]  WB_CTI_CLASSIC   = 3'b000;
    localparam logic [1:0]  WB_BTE_LINEAR    = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Prefetch FIFO with show-ahead head and flush.
// An empty FIFO keeps presenting the most recently popped entry.
module rv32_fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem [DEPTH];
    fetch_entry_t last_q;
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign head    = empty ? last_q : mem[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
            if (do_pop) begin
                last_q <= mem[rd_q];
            end
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch: Wishbone classic master feeding a prefetch FIFO.
// Define RV32_FETCH_ERR_EN to turn ibus__err into faulting entries and a HALT state.
module rv32_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] ibus__adr,
    output logic [31:0] ibus__dat_w,
    input  logic [31:0] ibus__dat_r,
    output logic [3:0]  ibus__sel,
    output logic        ibus__cyc,
    output logic        ibus__stb,
    input  logic        ibus__ack,
    output logic        ibus__we,
    output logic [2:0]  ibus__cti,
    output logic [1:0]  ibus__bte,
    input  logic        ibus__err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn_data,
    output logic [31:0] insn_pc,
    output logic        insn_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   fpc_q;
    logic [31:0]   fpc_d;
    logic [29:0]   drain_adr_q;
    logic [CW-1:0] count;
    logic [CW-1:0] after_ack;
    logic          push;
    logic          pop;
    logic          empty;
    logic          bus_err;
    logic          term;
    logic          unused_ok;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

`ifdef RV32_FETCH_ERR_EN
    assign bus_err    = ibus__err;
    assign insn_fault = head.fault;
    assign unused_ok  = ^redirect_pc[1:0];
`else
    assign bus_err    = 1'b0;
    assign insn_fault = 1'b0;
    assign unused_ok  = ^{redirect_pc[1:0], ibus__err, head.fault};
`endif

    assign term      = ibus__ack | bus_err;
    assign pop       = ~empty & insn_ready;
    assign after_ack = count + CW'(1) - CW'(pop);

    // DRAIN keeps the original address on the bus even after fpc moves on
    assign ibus__cyc   = (state_q == REQ) || (state_q == DRAIN);
    assign ibus__stb   = ibus__cyc;
    assign ibus__adr   = (state_q == DRAIN) ? drain_adr_q : fpc_q[31:2];
    assign ibus__dat_w = '0;
    assign ibus__sel   = 4'hF;
    assign ibus__we    = 1'b0;
    assign ibus__cti   = WB_CTI_CLASSIC;
    assign ibus__bte   = WB_BTE_LINEAR;

    assign insn_valid = ~empty;
    assign insn_data  = head.insn;
    assign insn_pc    = head.pc;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        push       = 1'b0;
        push_entry = '{pc: fpc_q, insn: ibus__dat_r, fault: 1'b0};
        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && count < CW'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    state_d = term ? IDLE : DRAIN;
                end else if (ibus__ack) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (after_ack < CW'(DEPTH)) ? REQ : IDLE;
`ifdef RV32_FETCH_ERR_EN
                end else if (bus_err) begin
                    push       = 1'b1;
                    push_entry = '{pc: fpc_q, insn: 32'h0, fault: 1'b1};
                    state_d    = HALT;
`endif
                end
            end
            DRAIN: begin
                if (term) begin
                    state_d = IDLE;
                end
            end
`ifdef RV32_FETCH_ERR_EN
            HALT: begin
                if (redirect_valid) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            drain_adr_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            if (state_q == REQ && state_d == DRAIN) begin
                drain_adr_q <= fpc_q[31:2];
            end
        end
    end

    rv32_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .wdata(push_entry),
        .head (head),
        .empty(empty),
        .count(count)
    );

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed bench for rv32_fetch with an in-bench Wishbone slave and
// a program-order stream model checked on every pop.
module tb_rv32_fetch;

`ifdef RV32_FETCH_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [29:0] ibus__adr;
    logic [31:0] ibus__dat_w;
    logic [31:0] ibus__dat_r;
    logic [3:0]  ibus__sel;
    logic        ibus__cyc;
    logic        ibus__stb;
    logic        ibus__ack;
    logic        ibus__we;
    logic [2:0]  ibus__cti;
    logic [1:0]  ibus__bte;
    logic        ibus__err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn_data;
    logic [31:0] insn_pc;
    logic        insn_fault;

    rv32_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .ibus__adr     (ibus__adr),
        .ibus__dat_w   (ibus__dat_w),
        .ibus__dat_r   (ibus__dat_r),
        .ibus__sel     (ibus__sel),
        .ibus__cyc     (ibus__cyc),
        .ibus__stb     (ibus__stb),
        .ibus__ack     (ibus__ack),
        .ibus__we      (ibus__we),
        .ibus__cti     (ibus__cti),
        .ibus__bte     (ibus__bte),
        .ibus__err     (ibus__err),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .insn_data     (insn_data),
        .insn_pc       (insn_pc),
        .insn_fault    (insn_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } ent_t;

    int          passed = 0;
    int          total  = 0;
    int          lat    = 1;
    int          wcnt   = 0;
    int          acks   = 0;
    bit          err_arm   = 0;
    bit          err_model = 0;
    logic [29:0] err_adr   = '0;
    ent_t        dq[$];

    logic [31:0] exp_pc;
    bit          halted;
    bit          open_q;
    bit          post_redir;
    logic [29:0] prev_adr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, want);
    endtask

    task automatic slave_update();
        if (ibus__ack || ibus__err) begin
            ibus__ack = 1'b0;
            ibus__err = 1'b0;
            wcnt = 0;
        end else if (ibus__cyc && ibus__stb) begin
            wcnt++;
            if (err_arm && ibus__adr == err_adr) begin
                err_arm   = 1'b0;
                ibus__err = 1'b1;
            end else if (wcnt >= lat) begin
                ibus__ack   = 1'b1;
                ibus__dat_r = word(ibus__adr);
                acks++;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        slave_update();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic rdy, input int l);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        insn_ready = rdy;
        ibus__ack = 1'b0;
        ibus__err = 1'b0;
        ibus__dat_r = '0;
        wcnt = 0;
        acks = 0;
        lat = l;
        err_arm = 1'b0;
        err_model = 1'b0;
        dq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", ibus__cyc, 0);
        chk("rst_stb", ibus__stb, 0);
        chk("rst_valid", insn_valid, 0);
        chk("rst_data", insn_data, 0);
        chk("rst_pc", insn_pc, 0);
        chk("rst_fault", insn_fault, 0);
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input logic [29:0] want, input string nm);
        int n = 0;
        while (!(ibus__cyc && ibus__adr == want) && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_cyc"}, ibus__cyc, 1);
        chk({nm, "_adr"}, {2'b00, ibus__adr}, {2'b00, want});
    endtask

    // Stream model: pops must follow program order from the last redirect
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_pc = 32'h0000_0000;
            halted = 1'b0;
            open_q = 1'b0;
            post_redir = 1'b0;
        end else begin
            if (open_q) begin
                chk("bus_hold_cyc", ibus__cyc, 1);
                chk("bus_hold_adr", {2'b00, ibus__adr}, {2'b00, prev_adr});
            end
            if (post_redir) chk("valid_after_redirect", insn_valid, 0);
            if (halted && !redirect_valid) chk("valid_while_halted", insn_valid, 0);
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                halted = 1'b0;
            end else if (insn_valid && insn_ready && !halted) begin
                logic ef;
                ef = ERR_EN && err_model && (exp_pc == {err_adr, 2'b00});
                chk("pop_pc", insn_pc, exp_pc);
                chk("pop_data", insn_data, ef ? 32'h0 : word(exp_pc[31:2]));
                chk("pop_fault", insn_fault, ef);
                dq.push_back('{pc: insn_pc, data: insn_data, fault: insn_fault});
                if (ef) begin
                    halted = 1'b1;
                    err_model = 1'b0;
                end
                exp_pc = exp_pc + 32'd4;
            end
            open_q = ibus__cyc && ibus__stb &&
                     !(ibus__ack || (ERR_EN && ibus__err));
            prev_adr = ibus__adr;
            post_redir = redirect_valid;
        end
    end

    initial begin
        rst = 1'b1;

        // Streaming after reset release
        do_reset(1'b1, 1);
        step();
        chk("t1_cyc_first", ibus__cyc, 1);
        chk("t1_adr_first", {2'b00, ibus__adr}, 0);
        run(12);
        chk("t1_count", dq.size() >= 3, 1);
        if (dq.size() >= 3) begin
            chk("t1_pc0", dq[0].pc, 32'h0);
            chk("t1_d0", dq[0].data, 32'hDEAD_BEEF);
            chk("t1_pc1", dq[1].pc, 32'h4);
            chk("t1_d1", dq[1].data, 32'hDEAD_BEEB);
            chk("t1_pc2", dq[2].pc, 32'h8);
            chk("t1_d2", dq[2].data, 32'hDEAD_BEE7);
        end

        // Backpressure fills both slots then stops the bus
        do_reset(1'b0, 1);
        run(20);
        chk("t2_acks", acks, 2);
        chk("t2_cyc_idle", ibus__cyc, 0);
        chk("t2_head_pc", insn_pc, 32'h0);
        insn_ready = 1'b1;
        run(20);
        chk("t2_count", dq.size() >= 4, 1);
        if (dq.size() >= 4) begin
            chk("t2_pc2", dq[2].pc, 32'h8);
            chk("t2_pc3", dq[3].pc, 32'hC);
        end

        // Redirect while a request is pending
        do_reset(1'b1, 4);
        run(2);
        redirect(32'h0000_1003);
        chk("t3_drain_cyc", ibus__cyc, 1);
        chk("t3_drain_adr", {2'b00, ibus__adr}, 0);
        wait_req(30'h400, "t3_next");
        run(30);
        chk("t3_count", dq.size() >= 1, 1);
        if (dq.size() >= 1) begin
            chk("t3_pc0", dq[0].pc, 32'h1000);
            chk("t3_d0", dq[0].data, 32'hDEAD_AEEF);
        end

        // Redirect colliding with ack and pop
        do_reset(1'b0, 1);
        begin
            int n = 0;
            while (!(ibus__ack && insn_valid) && n < 20) begin
                step();
                n++;
            end
        end
        chk("t4_sync", ibus__ack && insn_valid, 1);
        dq.delete();
        insn_ready = 1'b1;
        redirect(32'h0000_2000);
        wait_req(30'h800, "t4_next");
        run(10);
        chk("t4_count", dq.size() >= 1, 1);
        if (dq.size() >= 1) chk("t4_pc0", dq[0].pc, 32'h2000);

        // Fetch address wrap
        do_reset(1'b1, 1);
        run(6);
        dq.delete();
        redirect(32'hFFFF_FFFE);
        run(12);
        chk("t5_count", dq.size() >= 2, 1);
        if (dq.size() >= 2) begin
            chk("t5_pc0", dq[0].pc, 32'hFFFF_FFFC);
            chk("t5_d0", dq[0].data, 32'h2152_4113);
            chk("t5_pc1", dq[1].pc, 32'h0);
        end

        // Bus error at pc 0x20
        do_reset(1'b1, 1);
        err_adr = 30'h8;
        err_arm = 1'b1;
        err_model = 1'b1;
        run(40);
`ifdef RV32_FETCH_ERR_EN
        chk("t6_count", dq.size(), 9);
        chk("t6_cyc_halt", ibus__cyc, 0);
        if (dq.size() >= 9) begin
            chk("t6_pc", dq[8].pc, 32'h20);
            chk("t6_data", dq[8].data, 32'h0);
            chk("t6_fault", dq[8].fault, 1);
        end
        dq.delete();
        redirect(32'h0000_0040);
        run(10);
        chk("t6_resume", dq.size() >= 1, 1);
        if (dq.size() >= 1) chk("t6_resume_pc", dq[0].pc, 32'h40);
`else
        chk("t6_count", dq.size() > 9, 1);
        if (dq.size() > 9) begin
            chk("t6_pc", dq[8].pc, 32'h20);
            chk("t6_data", dq[8].data, 32'hDEAD_BECF);
            chk("t6_fault", dq[8].fault, 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
